// File: rtl/alu_seq.sv
// Registered ALU with a B-operand from the mux; single-cycle ops plus a
// shift-add multiply sequenced by a two-state FSM with start/busy/done handshake.
module alu_seq #(
  parameter int WIDTH   = 11,
  parameter int SHAMT_W = 4
) (
  input  logic             clock_in,
  input  logic             reset_in,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] MB_in,
  input  logic [3:0]       op_in,
  input  logic             start_in,
  output logic [WIDTH-1:0] result_out,
  output logic             Z_out,
  output logic             N_out,
  output logic             C_out,
  output logic             V_out,
  output logic             busy_out,
  output logic             done_out,
  output logic             state_dbg
);

  // Handshake: a request is start_in=1 sampled at a rising edge while
  // busy_out=0; done_out pulses for exactly one cycle after the edge that
  // updates result_out and the flags. Requests while busy_out=1 are dropped.

  localparam int CNT_W = $clog2(WIDTH);
  localparam int PW    = 2 * WIDTH;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_NOT   = 4'd5;
  localparam logic [3:0] OP_SHL   = 4'd6;
  localparam logic [3:0] OP_SHR   = 4'd7;
  localparam logic [3:0] OP_SRA   = 4'd8;
  localparam logic [3:0] OP_MUL   = 4'd9;
  localparam logic [3:0] OP_PASSB = 4'd10;

  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [PW-1:0]    mcand, mcand_nxt, prod, prod_nxt, prod_step;
  logic [WIDTH-1:0] mplier, mplier_nxt;
  logic [WIDTH-1:0] res_nxt;
  logic             z_nxt, n_nxt, c_nxt, v_nxt, done_nxt;

  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH:0]     add_w, sub_w, shl_w, shr_w;
  logic [WIDTH-1:0]   sra_res;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_v, alu_legal;

  assign shamt = MB_in[SHAMT_W-1:0];
  assign add_w = {1'b0, A_in} + {1'b0, MB_in};
  assign sub_w = {1'b0, A_in} - {1'b0, MB_in};
  // One extra bit on each shift catches the last bit shifted out, which is
  // exactly the carry; amounts past WIDTH shift it out too, giving C=0.
  assign shl_w   = {1'b0, A_in} << shamt;
  assign shr_w   = {A_in, 1'b0} >> shamt;
  assign sra_res = $signed(A_in) >>> shamt;

  always_comb begin
    alu_res   = '0;
    alu_c     = 1'b0;
    alu_v     = 1'b0;
    alu_legal = 1'b1;
    case (op_in)
      OP_ADD: begin
        alu_res = add_w[WIDTH-1:0];
        alu_c   = add_w[WIDTH];
        alu_v   = (A_in[WIDTH-1] == MB_in[WIDTH-1]) && (add_w[WIDTH-1] != A_in[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_w[WIDTH-1:0];
        alu_c   = ~sub_w[WIDTH];
        alu_v   = (A_in[WIDTH-1] != MB_in[WIDTH-1]) && (sub_w[WIDTH-1] != A_in[WIDTH-1]);
      end
      OP_AND:   alu_res = A_in & MB_in;
      OP_OR:    alu_res = A_in | MB_in;
      OP_XOR:   alu_res = A_in ^ MB_in;
      OP_NOT:   alu_res = ~A_in;
      OP_SHL: begin
        alu_res = shl_w[WIDTH-1:0];
        alu_c   = shl_w[WIDTH];
      end
      OP_SHR: begin
        alu_res = shr_w[WIDTH:1];
        alu_c   = shr_w[0];
      end
      OP_SRA: begin
        alu_res = sra_res;
        alu_c   = shr_w[0];
      end
      OP_PASSB: alu_res = MB_in;
      default:  alu_legal = 1'b0;
    endcase
  end

  // Multiplicand is pre-shifted each iteration, so bit 0 of the shifting
  // multiplier selects multiplicand<<counter.
  assign prod_step = prod + (mplier[0] ? mcand : '0);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    mcand_nxt  = mcand;
    mplier_nxt = mplier;
    prod_nxt   = prod;
    res_nxt    = result_out;
    z_nxt      = Z_out;
    n_nxt      = N_out;
    c_nxt      = C_out;
    v_nxt      = V_out;
    done_nxt   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_in) begin
          if (op_in == OP_MUL) begin
            mcand_nxt  = {{WIDTH{1'b0}}, A_in};
            mplier_nxt = MB_in;
            prod_nxt   = '0;
            cnt_nxt    = '0;
            state_nxt  = S_MUL;
          end else begin
            done_nxt = 1'b1;
            if (alu_legal) begin
              res_nxt = alu_res;
              z_nxt   = (alu_res == '0);
              n_nxt   = alu_res[WIDTH-1];
              c_nxt   = alu_c;
              v_nxt   = alu_v;
            end
          end
        end
      end
      S_MUL: begin
        prod_nxt   = prod_step;
        mcand_nxt  = mcand << 1;
        mplier_nxt = mplier >> 1;
        cnt_nxt    = cnt + 1'b1;
        if (cnt == CNT_W'(WIDTH - 1)) begin
          cnt_nxt   = '0;
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
          res_nxt   = prod_step[WIDTH-1:0];
          z_nxt     = (prod_step[WIDTH-1:0] == '0);
          n_nxt     = prod_step[WIDTH-1];
          c_nxt     = |prod_step[PW-1:WIDTH];
          v_nxt     = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state      <= S_IDLE;
      cnt        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      prod       <= '0;
      result_out <= '0;
      Z_out      <= 1'b0;
      N_out      <= 1'b0;
      C_out      <= 1'b0;
      V_out      <= 1'b0;
      done_out   <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      mcand      <= mcand_nxt;
      mplier     <= mplier_nxt;
      prod       <= prod_nxt;
      result_out <= res_nxt;
      Z_out      <= z_nxt;
      N_out      <= n_nxt;
      C_out      <= c_nxt;
      V_out      <= v_nxt;
      done_out   <= done_nxt;
    end
  end

  assign busy_out  = (state == S_MUL);
  assign state_dbg = state;

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Arithmetic/logic unit fed directly by the B-operand multiplexer. A comes from the accumulator; B is the mux output, which is either the sign-extended immediate or the data-memory word.
- Single-cycle ops finish in one clock. Multiply is a multi-cycle shift-add sequence.
- Results and flags are registered. A start/busy/done handshake lets the control unit stall while a multiply runs.

Parameters:
- WIDTH, 11, data path width in bits; must match the mux B output width.
- SHAMT_W, 4, number of low B bits used as the shift amount.

Ports:
- clock_in  input  1  system clock; all state changes on its rising edge.
- reset_in  input  1  reset, synchronous, active-high.
- A_in  input  WIDTH  operand A (accumulator).
- MB_in  input  WIDTH  operand B (mux B output).
- op_in  input  4  operation select, sampled with start_in.
- start_in  input  1  request; accepted only when busy_out=0.
- result_out  output  WIDTH  registered result.
- Z_out, N_out, C_out, V_out  output  1 each  registered zero, negative, carry, overflow flags.
- busy_out  output  1  high while a multiply is iterating.
- done_out  output  1  one-cycle pulse when result_out/flags have just been updated.

Behaviour:
- Reset (sampled at a rising edge with reset_in=1):
  - result_out=0, all flags=0, busy_out=0, done_out=0, FSM=IDLE, iteration counter=0.
  - Reset has priority over every other input, including in the middle of a multiply: the operation is aborted with no done pulse.
- FSM states: IDLE, MUL.
  - IDLE, start_in=1, op!=MUL: result and flags are written at that same edge; done_out=1 for the next cycle; stay IDLE.
  - IDLE, start_in=1, op=MUL: latch A/B, clear the 2*WIDTH product, counter=0, busy_out=1, go to MUL.
  - MUL: each edge, if multiplier bit[counter]=1, add multiplicand<<counter to the product; then counter+1.
  - On the edge where counter reaches WIDTH-1: write result_out, busy_out=0, done_out=1 for the next cycle, go to IDLE.
  - MUL latency: start edge plus WIDTH iteration edges, so done_out is high in the cycle after edge 11 for WIDTH=11.
  - start_in while busy_out=1 is ignored, and op_in/A_in/MB_in changes during MUL have no effect.
  - start_in is accepted in the same cycle done_out is high, provided busy_out=0.
- Opcodes:
  - 0 ADD: A+B.
  - 1 SUB: A-B.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 NOT: ~A.
  - 6 SHL: A<<n.
  - 7 SHR: logical A>>n.
  - 8 SRA: arithmetic A>>n.
  - 9 MUL: low WIDTH bits of A*B, unsigned.
  - 10 PASSB: result=B.
  - 11-15: illegal; result_out and flags hold their values, but done_out still pulses.
- Shift amount: n = MB_in[SHAMT_W-1:0].
  - n=0: result=A.
  - n>=WIDTH: SHL/SHR give 0; SRA gives all bits equal to A[WIDTH-1].
- Z and N: Z = (result==0); N = result[WIDTH-1]. Updated for every legal op.
- C flag:
  - ADD: carry-out.
  - SUB: 1 when A>=B unsigned (no borrow).
  - Shifts with n in 1..WIDTH:
    - SHL: C = A[WIDTH-n].
    - SHR/SRA: C = A[n-1].
  - Shifts with n=0 or n>WIDTH: C=0.
  - MUL: C=1 if any product bit above WIDTH-1 is nonzero.
  - All other ops: C=0.
- V flag:
  - ADD: 1 when A and B have the same sign and the result sign differs.
  - SUB: 1 when A and B have different signs and the result sign differs from A.
  - All other ops: V=0.
- Internal arithmetic uses WIDTH+1 bits for ADD/SUB and 2*WIDTH bits for MUL; outputs are truncated to WIDTH.

Test Plan:
- ADD A=2047, B=1 -> result=0, Z=1, C=1, V=0, N=0; done_out one cycle; busy_out stays 0.
- SUB A=5, B=7 -> result=2046, N=1, C=0, V=0; then ADD A=1023, B=1 -> result=1024, N=1, V=1, C=0.
- MUL A=45, B=45 -> busy_out high for 11 cycles, then result=2025, C=0, done pulse; MUL A=100, B=30 -> result=952, C=1.
- SHL A=11'b10000000001, n=1 -> result=2, C=1; SRA A=11'b10000000000, n=15 -> result=2047, N=1, C=0; SHR n=0 -> result=A, C=0.
- During a MUL, assert start_in with op=ADD at iteration 3 -> ignored, MUL result unchanged; op=12 in IDLE -> result/flags hold, done pulses.
- Reset at iteration 5 of a MUL -> next cycle busy_out=0, result_out=0, flags=0, no done pulse; a new ADD after reset completes normally.
